// File: rtl/adc_capture_writer_if.sv
// Single-word write request bus between the ADC capture writer
// and the SDRAM interface.
interface adc_capture_writer_if;
  logic [15:0] MemData;
  logic [21:0] MemAddress;
  logic        MemReq;
  logic        MemWnR;
  logic        MemBusy;
  logic        MemAck;

  modport master (
    output MemData,
    output MemAddress,
    output MemReq,
    output MemWnR,
    input  MemBusy,
    input  MemAck
  );

  modport slave (
    input  MemData,
    input  MemAddress,
    input  MemReq,
    input  MemWnR,
    output MemBusy,
    output MemAck
  );
endinterface

// File: rtl/adc_capture_writer.sv
// Captures a programmed number of ADC samples into a small FIFO and
// writes them to consecutive SDRAM words, one registered request at a time.
module adc_capture_writer #(
  parameter int ADC_WIDTH = 12,
  parameter int FIFO_AW   = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [ADC_WIDTH-1:0] AdcData,
  input  logic                 AdcValid,
  input  logic                 Start,
  input  logic [21:0]          BaseAddress,
  input  logic [21:0]          Length,
  output logic                 Capturing,
  output logic                 Done,
  output logic                 Overflow,
  output logic [21:0]          SampleCount,
  adc_capture_writer_if.master mem
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_OCC = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]  state;
  logic [21:0] base_q;
  logic [21:0] len_q;
  logic [21:0] accepted;
  logic [21:0] sample_cnt;
  logic        ovf_q;
  logic        req_q;
  logic [15:0] data_q;
  logic [21:0] addr_q;

  logic [ADC_WIDTH-1:0] fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [FIFO_AW:0]     occ;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic issue;
  logic ovf_set;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);
  assign pop   = req_q && mem.MemAck;

  // A full FIFO still takes a sample when the head leaves on the same edge.
  assign push    = (state == S_CAPTURE) && AdcValid && (!full || pop);
  assign ovf_set = (state == S_CAPTURE) && AdcValid && full && !pop;

  // Ack must be low too: a stale Ack from the previous write would
  // otherwise complete the next request immediately.
  assign issue = !req_q && !mem.MemBusy && !mem.MemAck && !empty;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      accepted   <= '0;
      sample_cnt <= '0;
      ovf_q      <= 1'b0;
      req_q      <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      if (issue) begin
        req_q  <= 1'b1;
        data_q <= 16'(fifo_mem[rd_ptr]);
        addr_q <= base_q + sample_cnt;
      end else if (pop) begin
        req_q <= 1'b0;
      end
      if (pop) sample_cnt <= sample_cnt + 22'd1;
      if (ovf_set) ovf_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (Start) begin
            base_q     <= BaseAddress;
            len_q      <= Length;
            accepted   <= '0;
            sample_cnt <= '0;
            ovf_q      <= 1'b0;
            state      <= (Length == '0) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (push) begin
            accepted <= accepted + 22'd1;
            if (accepted + 22'd1 == len_q) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (sample_cnt == len_q && !req_q) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= AdcData;
  end

  assign Capturing      = (state != S_IDLE);
  assign Done           = (state == S_DONE);
  assign Overflow       = ovf_q;
  assign SampleCount    = sample_cnt;
  assign mem.MemReq     = req_q;
  assign mem.MemData    = data_q;
  assign mem.MemAddress = addr_q;
  assign mem.MemWnR     = 1'b1;

endmodule

// File: tb/tb_adc_capture_writer.sv
// Randomized bench for adc_capture_writer: an SDRAM responder checks
// every completed write against a queue of expected address/data pairs.
module tb_adc_capture_writer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [11:0] AdcData = '0;
  logic        AdcValid = 1'b0;
  logic        Start = 1'b0;
  logic [21:0] BaseAddress = '0;
  logic [21:0] Length = '0;
  logic        Capturing;
  logic        Done;
  logic        Overflow;
  logic [21:0] SampleCount;

  adc_capture_writer_if ifc ();

  adc_capture_writer #(.ADC_WIDTH(12), .FIFO_AW(4)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .AdcData     (AdcData),
    .AdcValid    (AdcValid),
    .Start       (Start),
    .BaseAddress (BaseAddress),
    .Length      (Length),
    .Capturing   (Capturing),
    .Done        (Done),
    .Overflow    (Overflow),
    .SampleCount (SampleCount),
    .mem         (ifc.master)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [21:0] exp_a [$];
  logic [15:0] exp_d [$];

  int ack_delay = 1;
  int ack_hold  = 1;
  int wait_cnt  = 0;
  int hold_cnt  = 0;
  int done_cnt  = 0;
  int req_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (ifc.MemReq) req_cnt++;
  end

  // SDRAM responder: acks after ack_delay cycles of Req, holds Ack ack_hold cycles.
  initial begin
    ifc.MemAck = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        ifc.MemAck = 1'b0;
        wait_cnt = 0;
        hold_cnt = 0;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) ifc.MemAck = 1'b0;
      end else if (ifc.MemReq && !ifc.MemBusy) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          ifc.MemAck = 1'b1;
          hold_cnt = ack_hold;
          if (exp_a.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            check("wr_addr", 32'(ifc.MemAddress), 32'(exp_a.pop_front()));
            check("wr_data", 32'(ifc.MemData), 32'(exp_d.pop_front()));
          end
        end
      end
    end
  end

  task automatic do_start(input logic [21:0] base, input logic [21:0] len);
    @(negedge Clk);
    Start = 1'b1;
    BaseAddress = base;
    Length = len;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Feeds n samples; the first n_keep are expected to reach SDRAM at
  // base+first_idx onwards.
  task automatic feed(input int n, input int n_keep, input logic [11:0] d0,
                      input logic [21:0] base, input int first_idx,
                      input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge Clk);
        AdcValid = 1'b0;
      end
      @(negedge Clk);
      AdcValid = 1'b1;
      AdcData = d0 + 12'(i);
      if (i < n_keep) begin
        exp_a.push_back(base + 22'(first_idx + i));
        exp_d.push_back(16'(d0 + 12'(i)));
      end
    end
    @(negedge Clk);
    AdcValid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!Done && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(Done), 1);
    @(negedge Clk);
    check({tag, "_done_pulse"}, 32'(Done), 0);
  endtask

  initial begin
    int dc;
    int rc;
    int n;
    logic [21:0] base;
    logic [21:0] len;

    ifc.MemBusy = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_req", 32'(ifc.MemReq), 0);
    check("rst_wnr", 32'(ifc.MemWnR), 1);
    check("rst_capturing", 32'(Capturing), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_overflow", 32'(Overflow), 0);
    check("rst_count", 32'(SampleCount), 0);
    check("rst_addr", 32'(ifc.MemAddress), 0);
    check("rst_data", 32'(ifc.MemData), 0);
    Rst = 1'b0;

    // Basic four-sample capture
    dc = done_cnt;
    do_start(22'h000100, 22'd4);
    check("t1_capturing", 32'(Capturing), 1);
    feed(4, 4, 12'h001, 22'h000100, 0, 0);
    wait_done("t1", 100);
    check("t1_count", 32'(SampleCount), 4);
    check("t1_overflow", 32'(Overflow), 0);
    check("t1_done_cnt", 32'(done_cnt - dc), 1);
    check("t1_exp_empty", 32'(exp_a.size()), 0);
    check("t1_idle", 32'(Capturing), 0);

    // AdcValid in IDLE is ignored
    rc = req_cnt;
    repeat (3) begin
      @(negedge Clk);
      AdcValid = 1'b1;
      AdcData = 12'hABC;
    end
    @(negedge Clk);
    AdcValid = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_valid_ovf", 32'(Overflow), 0);
    check("idle_valid_req", 32'(req_cnt - rc), 0);

    // Zero length: Done without any request
    rc = req_cnt;
    dc = done_cnt;
    do_start(22'h000200, 22'd0);
    wait_done("t2", 3);
    @(negedge Clk);
    check("t2_no_req", 32'(req_cnt - rc), 0);
    check("t2_done_cnt", 32'(done_cnt - dc), 1);
    check("t2_count", 32'(SampleCount), 0);

    // Busy SDRAM: FIFO fills, last four samples dropped
    dc = done_cnt;
    ifc.MemBusy = 1'b1;
    do_start(22'h002000, 22'd20);
    feed(20, 16, 12'h100, 22'h002000, 0, 0);
    check("t3_overflow", 32'(Overflow), 1);
    check("t3_capturing", 32'(Capturing), 1);
    check("t3_count0", 32'(SampleCount), 0);
    repeat (16) @(negedge Clk);
    ifc.MemBusy = 1'b0;
    repeat (80) @(negedge Clk);
    check("t3_no_done", 32'(done_cnt - dc), 0);
    check("t3_still_cap", 32'(Capturing), 1);
    check("t3_count16", 32'(SampleCount), 16);
    feed(4, 4, 12'h200, 22'h002000, 16, 0);
    wait_done("t3", 100);
    check("t3_count20", 32'(SampleCount), 20);
    check("t3_ovf_sticky", 32'(Overflow), 1);
    check("t3_exp_empty", 32'(exp_a.size()), 0);

    // Address wrap with Ack held for two cycles
    ack_hold = 2;
    do_start(22'h3FFFFE, 22'd3);
    check("t4_ovf_clr", 32'(Overflow), 0);
    feed(3, 3, 12'h7F0, 22'h3FFFFE, 0, 0);
    wait_done("t4", 100);
    check("t4_count", 32'(SampleCount), 3);
    check("t4_exp_empty", 32'(exp_a.size()), 0);

    // Randomized captures
    for (int it = 0; it < 12; it++) begin
      ack_delay = $urandom_range(3, 1);
      ack_hold = $urandom_range(2, 1);
      base = 22'($urandom);
      len = 22'($urandom_range(12, 1));
      dc = done_cnt;
      do_start(base, len);
      feed(int'(len), int'(len), 12'($urandom), base, 0, 2);
      wait_done("rnd", 200);
      check("rnd_count", 32'(SampleCount), 32'(len));
      check("rnd_overflow", 32'(Overflow), 0);
      check("rnd_done_cnt", 32'(done_cnt - dc), 1);
      check("rnd_exp_empty", 32'(exp_a.size()), 0);
    end

    // Reset while a request is outstanding
    ack_delay = 30;
    ack_hold = 1;
    dc = done_cnt;
    do_start(22'h005000, 22'd6);
    feed(6, 1, 12'h300, 22'h005000, 0, 0);
    n = 0;
    while (!ifc.MemReq && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("t6_req_seen", 32'(ifc.MemReq), 1);
    #2 Rst = 1'b1;
    #1;
    check("t6_req_drop", 32'(ifc.MemReq), 0);
    check("t6_cap_drop", 32'(Capturing), 0);
    exp_a.delete();
    exp_d.delete();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    ack_delay = 1;
    do_start(22'h000040, 22'd2);
    feed(2, 2, 12'h0AA, 22'h000040, 0, 0);
    wait_done("t6", 100);
    check("t6_count", 32'(SampleCount), 2);
    check("t6_done_cnt", 32'(done_cnt - dc), 1);
    check("t6_exp_empty", 32'(exp_a.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
